// File: rtl/pipeline_control_unit_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush sequencer.
interface pipeline_control_unit_if #(
  parameter int COUNT_WIDTH = 32
);
  // Hazard and memory status coming from the pipeline
  logic                   load_use_stall;
  logic                   EX_branch_taken;
  logic                   MEM_mem_access;
  logic                   dmem_ready;
  logic                   WB_halt;

  // Enables, flushes and status going back to the pipeline
  logic                   pc_write;
  logic                   IF_ID_write;
  logic                   IF_ID_flush;
  logic                   ID_EX_write;
  logic                   ID_EX_flush;
  logic                   EX_MEM_write;
  logic                   MEM_WB_write;
  logic                   dmem_req;
  logic                   halted;
  logic                   mem_error;
  logic [COUNT_WIDTH-1:0] bubble_count;
  logic [COUNT_WIDTH-1:0] freeze_count;

  // Pipeline side: raises hazards, consumes enables
  modport master (
    output load_use_stall, EX_branch_taken, MEM_mem_access, dmem_ready, WB_halt,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, MEM_WB_write, dmem_req, halted, mem_error,
           bubble_count, freeze_count
  );

  // Control-unit side: consumes hazards, produces enables
  modport slave (
    input  load_use_stall, EX_branch_taken, MEM_mem_access, dmem_ready, WB_halt,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, MEM_WB_write, dmem_req, halted, mem_error,
           bubble_count, freeze_count
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline. Outputs are Mealy so
// a stall or freeze acts in the same cycle the hazard is seen; state, the
// memory wait counter, the sticky error and the debug counters are registered.
module pipeline_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_control_unit_if.slave bus
);

  localparam int WAIT_W_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int WAIT_W     = (WAIT_W_RAW < 1) ? 1 : WAIT_W_RAW;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [WAIT_W-1:0]      TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]      WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0]      WAIT_ONE  = WAIT_W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] bubble_q, bubble_d;
  logic [COUNT_WIDTH-1:0] freeze_q, freeze_d;
  logic                   mem_error_q, mem_error_d;

  logic [WAIT_W-1:0]      wait_inc_s;
  logic                   freeze_s;
  logic                   timeout_s;

  logic pc_write_s, if_id_write_s, if_id_flush_s, id_ex_write_s, id_ex_flush_s;
  logic ex_mem_write_s, mem_wb_write_s, dmem_req_s, halted_s;

  assign wait_inc_s = wait_q + WAIT_ONE;

  // Freeze condition per state and detection of the memory timeout
  always_comb begin
    freeze_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      ST_RUN:      freeze_s = bus.MEM_mem_access & ~bus.dmem_ready;
      ST_MEM_WAIT: begin
        freeze_s  = ~bus.dmem_ready;
        // Timeout fires when this wait cycle would bring the count to MEM_TIMEOUT
        timeout_s = TIMEOUT_EN & ~bus.dmem_ready & (wait_inc_s == TIMEOUT_V);
      end
      ST_HALTED:   freeze_s = 1'b1;
      default:     freeze_s = 1'b1;
    endcase
  end

  // State register with synchronous reset back to RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (freeze_s) begin
          state_d = ST_MEM_WAIT;
        end else if (bus.WB_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // The release cycle is unfrozen, so a halt reaching WB then still counts
        if (bus.dmem_ready) begin
          state_d = bus.WB_halt ? ST_HALTED : ST_RUN;
        end else if (timeout_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Mealy outputs: reset clears registers, freeze holds all, then halt > branch > load-use
  always_comb begin
    pc_write_s     = 1'b0;
    if_id_write_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_write_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_write_s = 1'b0;
    mem_wb_write_s = 1'b0;
    dmem_req_s     = 1'b0;
    halted_s       = 1'b0;
    if (reset) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else begin
      case (state_q)
        ST_RUN:      dmem_req_s = bus.MEM_mem_access;
        ST_MEM_WAIT: dmem_req_s = 1'b1;
        ST_HALTED:   halted_s   = 1'b1;
        default:     dmem_req_s = 1'b0;
      endcase
      if (freeze_s) begin
        pc_write_s = 1'b0;
      end else if (bus.WB_halt) begin
        mem_wb_write_s = 1'b1;
      end else if (bus.EX_branch_taken) begin
        // Redirect: younger instructions in IF/ID and ID are squashed
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b1;
        id_ex_write_s  = 1'b1;
        id_ex_flush_s  = 1'b1;
        ex_mem_write_s = 1'b1;
        mem_wb_write_s = 1'b1;
      end else if (bus.load_use_stall) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX
        id_ex_write_s  = 1'b1;
        id_ex_flush_s  = 1'b1;
        ex_mem_write_s = 1'b1;
        mem_wb_write_s = 1'b1;
      end else begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        id_ex_write_s  = 1'b1;
        ex_mem_write_s = 1'b1;
        mem_wb_write_s = 1'b1;
      end
    end
  end

  // Next values of the wait counter, sticky error and saturating debug counters
  always_comb begin
    if (state_q == ST_MEM_WAIT) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_inc_s;
    end else begin
      // Leaving zero here means entry into MEM_WAIT always starts from 0
      wait_d = {WAIT_W{1'b0}};
    end
    mem_error_d = mem_error_q | timeout_s;
    if (id_ex_flush_s && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_ONE;
    end else begin
      bubble_d = bubble_q;
    end
    if (freeze_s && (state_q != ST_HALTED) && (freeze_q != CNT_MAX)) begin
      freeze_d = freeze_q + CNT_ONE;
    end else begin
      freeze_d = freeze_q;
    end
  end

  // Registers for the wait counter, sticky error and debug counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q      <= {WAIT_W{1'b0}};
      mem_error_q <= 1'b0;
      bubble_q    <= {COUNT_WIDTH{1'b0}};
      freeze_q    <= {COUNT_WIDTH{1'b0}};
    end else begin
      wait_q      <= wait_d;
      mem_error_q <= mem_error_d;
      bubble_q    <= bubble_d;
      freeze_q    <= freeze_d;
    end
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.IF_ID_write  = if_id_write_s;
  assign bus.IF_ID_flush  = if_id_flush_s;
  assign bus.ID_EX_write  = id_ex_write_s;
  assign bus.ID_EX_flush  = id_ex_flush_s;
  assign bus.EX_MEM_write = ex_mem_write_s;
  assign bus.MEM_WB_write = mem_wb_write_s;
  assign bus.dmem_req     = dmem_req_s;
  assign bus.halted       = halted_s;
  assign bus.mem_error    = mem_error_q & ~reset;
  assign bus.bubble_count = bubble_q;
  assign bus.freeze_count = freeze_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed, table-driven bench for pipeline_control_unit (MEM_TIMEOUT=4, COUNT_WIDTH=2).
module tb_pipeline_control_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  pipeline_control_unit_if #(.COUNT_WIDTH(2)) bus ();

  pipeline_control_unit #(
    .MEM_TIMEOUT(4),
    .COUNT_WIDTH(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {pc, IF_ID_w, IF_ID_f, ID_EX_w, ID_EX_f, EX_MEM_w, MEM_WB_w, dmem_req, halted, mem_error}
  logic [9:0] out_s;
  assign out_s = {bus.pc_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_write,
                  bus.ID_EX_flush, bus.EX_MEM_write, bus.MEM_WB_write, bus.dmem_req,
                  bus.halted, bus.mem_error};

  localparam logic [9:0] O_RST   = 10'b0010100000;
  localparam logic [9:0] O_NORM  = 10'b1101011000;
  localparam logic [9:0] O_NORMR = 10'b1101011100;
  localparam logic [9:0] O_LUS   = 10'b0001111000;
  localparam logic [9:0] O_BR    = 10'b1111111000;
  localparam logic [9:0] O_BRR   = 10'b1111111100;
  localparam logic [9:0] O_FRZ   = 10'b0000000100;
  localparam logic [9:0] O_HALT  = 10'b0000001000;
  localparam logic [9:0] O_HALTR = 10'b0000001100;
  localparam logic [9:0] O_HLTD  = 10'b0000000010;
  localparam logic [9:0] O_HLTE  = 10'b0000000011;

  // Input bundle: {reset, load_use_stall, EX_branch_taken, MEM_mem_access, dmem_ready, WB_halt}
  typedef struct {
    logic [5:0] in;
    logic [9:0] out;
    logic [1:0] b;
    logic [1:0] f;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

  task automatic apply(input logic [5:0] v);
    @(negedge clk);
    {reset, bus.load_use_stall, bus.EX_branch_taken, bus.MEM_mem_access,
     bus.dmem_ready, bus.WB_halt} = v;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int found;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{6'b100000, O_RST,   2'd0, 2'd0};
    vecs[1]  = '{6'b000000, O_NORM,  2'd0, 2'd0};
    vecs[2]  = '{6'b010000, O_LUS,   2'd0, 2'd0};  // load-use bubble
    vecs[3]  = '{6'b000000, O_NORM,  2'd1, 2'd0};
    vecs[4]  = '{6'b011000, O_BR,    2'd1, 2'd0};  // branch beats stall
    vecs[5]  = '{6'b001000, O_BR,    2'd2, 2'd0};
    vecs[6]  = '{6'b000000, O_NORM,  2'd3, 2'd0};
    vecs[7]  = '{6'b000110, O_NORMR, 2'd3, 2'd0};  // hit: no freeze
    vecs[8]  = '{6'b000100, O_FRZ,   2'd3, 2'd0};  // miss in RUN
    vecs[9]  = '{6'b001100, O_FRZ,   2'd3, 2'd1};  // freeze beats branch
    vecs[10] = '{6'b001100, O_FRZ,   2'd3, 2'd2};
    vecs[11] = '{6'b001110, O_BRR,   2'd3, 2'd3};  // release applies branch
    vecs[12] = '{6'b000000, O_NORM,  2'd3, 2'd3};  // bubble saturated at 3
    vecs[13] = '{6'b100000, O_RST,   2'd3, 2'd3};
    vecs[14] = '{6'b000000, O_NORM,  2'd0, 2'd0};
    vecs[15] = '{6'b000100, O_FRZ,   2'd0, 2'd0};
    vecs[16] = '{6'b000111, O_HALTR, 2'd0, 2'd1};  // release with halt
    vecs[17] = '{6'b011110, O_HLTD,  2'd0, 2'd1};
    vecs[18] = '{6'b010001, O_HLTD,  2'd0, 2'd1};  // HALTED not counted as freeze
    vecs[19] = '{6'b100000, O_RST,   2'd0, 2'd1};
    vecs[20] = '{6'b000000, O_NORM,  2'd0, 2'd0};
    vecs[21] = '{6'b000100, O_FRZ,   2'd0, 2'd0};  // timeout run: RUN miss
    vecs[22] = '{6'b000100, O_FRZ,   2'd0, 2'd1};  // wait 1
    vecs[23] = '{6'b001100, O_FRZ,   2'd0, 2'd2};  // wait 2
    vecs[24] = '{6'b010100, O_FRZ,   2'd0, 2'd3};  // wait 3
    vecs[25] = '{6'b000101, O_FRZ,   2'd0, 2'd3};  // wait 4, halt ignored
    vecs[26] = '{6'b000100, O_HLTE,  2'd0, 2'd3};
    vecs[27] = '{6'b000110, O_HLTE,  2'd0, 2'd3};
    vecs[28] = '{6'b100110, O_RST,   2'd0, 2'd3};
    vecs[29] = '{6'b000000, O_NORM,  2'd0, 2'd0};
    vecs[30] = '{6'b001001, O_HALT,  2'd0, 2'd0};  // halt beats branch
    vecs[31] = '{6'b010000, O_HLTD,  2'd0, 2'd0};
    vecs[32] = '{6'b100000, O_RST,   2'd0, 2'd0};
    vecs[33] = '{6'b000000, O_NORM,  2'd0, 2'd0};
    vecs[34] = '{6'b000100, O_FRZ,   2'd0, 2'd0};
    vecs[35] = '{6'b100100, O_RST,   2'd0, 2'd1};  // reset mid-wait drops req
    vecs[36] = '{6'b000000, O_NORM,  2'd0, 2'd0};

    reset = 1'b1;
    bus.load_use_stall  = 1'b0;
    bus.EX_branch_taken = 1'b0;
    bus.MEM_mem_access  = 1'b0;
    bus.dmem_ready      = 1'b0;
    bus.WB_halt         = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].in);
      check($sformatf("v%0d_out", i),    {22'd0, out_s},            {22'd0, vecs[i].out});
      check($sformatf("v%0d_bubble", i), {30'd0, bus.bubble_count}, {30'd0, vecs[i].b});
      check($sformatf("v%0d_freeze", i), {30'd0, bus.freeze_count}, {30'd0, vecs[i].f});
    end

    // Timeout latency: RUN miss plus four wait cycles, halted seen on cycle 5
    apply(6'b100000);
    found = -1;
    for (int c = 0; c < 20; c++) begin
      apply(6'b000100);
      if (bus.halted === 1'b1) begin
        found = c;
        break;
      end
    end
    check("timeout_latency", 32'(found), 32'd5);
    check("timeout_outputs", {22'd0, out_s}, {22'd0, O_HLTE});
    check("timeout_freeze_cnt", {30'd0, bus.freeze_count}, {30'd0, 2'd3});

    // HALTED is held with writes off while inputs toggle
    for (int k = 0; k < 8; k++) begin
      logic [4:0] r;
      r = 5'($urandom_range(0, 31));
      apply({1'b0, r});
      check($sformatf("halted_hold%0d", k), {22'd0, out_s}, {22'd0, O_HLTE});
    end

    // One reset cycle returns to RUN with counters and error cleared
    apply(6'b100000);
    check("reset_from_halt", {22'd0, out_s}, {22'd0, O_RST});
    apply(6'b000000);
    check("run_after_reset", {22'd0, out_s}, {22'd0, O_NORM});
    check("cnt_after_reset", {28'd0, bus.bubble_count, bus.freeze_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central stall/flush/freeze sequencer for the 5-stage RV32I pipeline. Combines the load-use stall request, the EX-stage branch/jump redirect, the data-memory ready handshake and the WB-stage halt into one consistent set of write enables and flush strobes. It covers the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating bubble and freeze counters, and a data-memory timeout, for debug.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: max consecutive MEM_WAIT cycles before error; 0 disables timeout.
- `COUNT_WIDTH`, 32: width of `bubble_count` and `freeze_count`.

Ports:
- `clk`  input  1  single clock, all state updates on rising edge.
- `reset`  input  1  synchronous, active-high.
- `load_use_stall`  input  1  load-use hazard detected for the ID instruction.
- `EX_branch_taken`  input  1  EX resolves a taken branch or a jump (jal/jalr).
- `MEM_mem_access`  input  1  MEM-stage instruction is a load or store.
- `dmem_ready`  input  1  data memory completes the current access this cycle.
- `WB_halt`  input  1  ecall/ebreak reached WB.
- `pc_write`  output  1  PC register load enable.
- `IF_ID_write`  output  1  IF/ID register load enable.
- `IF_ID_flush`  output  1  IF/ID loads a NOP.
- `ID_EX_write`  output  1  ID/EX register load enable.
- `ID_EX_flush`  output  1  ID/EX loads a bubble (all control zero).
- `EX_MEM_write`  output  1  EX/MEM load enable.
- `MEM_WB_write`  output  1  MEM/WB load enable.
- `dmem_req`  output  1  data-memory request valid.
- `halted`  output  1  core stopped.
- `mem_error`  output  1  timeout occurred; sticky until reset.
- `bubble_count`  output  COUNT_WIDTH  cycles with `ID_EX_flush` asserted.
- `freeze_count`  output  COUNT_WIDTH  cycles with the whole pipeline frozen.

## Operation
- FSM states are RUN, MEM_WAIT and HALTED. Outputs are combinational from the state and the current inputs (Mealy), so stalls take effect in the same cycle. State, the wait counter and the counters are registered.
- `freeze` in RUN = `MEM_mem_access & !dmem_ready`. In MEM_WAIT, `freeze` = `!dmem_ready`. In HALTED, `freeze` = 1.
- `dmem_req` = `MEM_mem_access` in RUN. It is 1 throughout MEM_WAIT and 0 in HALTED.
- Freeze makes all `*_write` signals 0 and both flushes 0. It overrides branch and stall.
- When not frozen, priority is: `WB_halt` > `EX_branch_taken` > `load_use_stall` > normal.
  - `WB_halt`: WB commits this cycle with `MEM_WB_write`=1 and all other writes 0. Next state is HALTED.
  - Branch: all writes 1, `IF_ID_flush`=1, `ID_EX_flush`=1. The PC loads the target, and the simultaneous load-use stall is discarded.
  - Load-use: `pc_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1. All other writes are 1.
  - Normal: all writes 1, no flush.
- Flush has precedence over write inside a pipeline register. `ID_EX_write` is 1 whenever `ID_EX_flush` is 1.
- State transitions:
  - RUN -> MEM_WAIT on `MEM_mem_access & !dmem_ready`.
  - MEM_WAIT -> RUN on `dmem_ready`. That cycle is unfrozen and applies the normal priority rules to the current inputs.
  - MEM_WAIT -> HALTED with `mem_error`=1 when `MEM_TIMEOUT`≠0 and the wait counter reaches `MEM_TIMEOUT` without `dmem_ready`.
  - HALTED is left only by reset.
- The wait counter is cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle. Its width is `$clog2(MEM_TIMEOUT+1)`, minimum 1.
- `bubble_count` increments on each cycle with `ID_EX_flush`=1. `freeze_count` increments on each cycle with `freeze`=1, excluding HALTED. Both saturate at all-ones.

## Timing
- While `reset`=1:
  - All `*_write`=0, `IF_ID_flush`=`ID_EX_flush`=1, so the pipeline registers clear.
  - `dmem_req`=0, `halted`=0, `mem_error`=0.
- On the first edge with `reset`=1, the counters and the wait counter go to 0 and the state goes to RUN. The first cycle after reset is RUN.
- Reset mid-MEM_WAIT or in HALTED returns to RUN on the next edge and drops `dmem_req` immediately.
- A load-use stall costs 1 bubble. A taken branch costs 2 flushed slots. A memory miss costs N freeze cycles, where N = cycles until `dmem_ready`.
- `dmem_ready` in the same RUN cycle as the request means zero freeze and no MEM_WAIT entry.
- `halted` is 1 from the first HALTED cycle. `mem_error` rises in the same cycle as the HALTED transition's next state, i.e. it is registered and visible on the next cycle.

## Test plan
- **Load-use:** assert `load_use_stall` for 1 cycle in RUN -> `pc_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1 that cycle, and `bubble_count` goes 0->1.
- **Branch vs. stall:** `EX_branch_taken`=1 and `load_use_stall`=1 together -> `pc_write`=1, `IF_ID_flush`=1, `ID_EX_flush`=1, and `bubble_count` +1.
- **Memory wait:** `MEM_mem_access`=1 with `dmem_ready` low for 3 cycles then high -> 3 cycles with all writes 0 and `dmem_req`=1, then one unfrozen cycle back in RUN, and `freeze_count`=3.
- **Freeze beats branch:** `EX_branch_taken`=1 during MEM_WAIT -> no flush and no write until `dmem_ready`, then the flush is applied in the release cycle if the branch is still asserted.
- **Timeout:** `MEM_TIMEOUT`=4 with `dmem_ready` held 0 -> HALTED after 4 wait cycles, `mem_error`=1, `halted`=1, all writes 0. Then assert `reset` for 1 cycle -> RUN, counters 0, `mem_error`=0.
- **Halt and saturation:** `WB_halt`=1 -> `MEM_WB_write`=1 only in that cycle, then `halted`=1 held indefinitely while inputs toggle. With `COUNT_WIDTH`=2 and 5 stall cycles, `bubble_count` saturates at 3.
